// File: rtl/ttni_pkg.sv
// rtl/ttni_pkg.sv - shared flit types, descriptor record and scheduler states for the TT network interface
package ttni_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int TTNI_DATA_W = 32;
  localparam int TTNI_LEN_W  = 8;

  typedef struct packed {
    logic [63:0]            rel_time;
    logic [TTNI_DATA_W-1:0] header;
    logic [TTNI_LEN_W-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY
  } sched_state_e;

endpackage

// File: rtl/ttni_desc_fifo.sv
// rtl/ttni_desc_fifo.sv - synchronous descriptor FIFO, first-word-fall-through read port
module ttni_desc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ttni_vc_source_sched.sv
// rtl/ttni_vc_source_sched.sv - time-triggered multi-VC flit source with round-robin release arbitration
module ttni_vc_source_sched
  import ttni_pkg::*;
#(
  parameter int VCHANNELS       = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int DESC_DEPTH      = 4,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_SLIP        = 16,
  parameter int LATE_DROP       = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_globle,
  input  logic [63:0]                            GTB,
  input  logic                                   desc_valid,
  output logic                                   desc_ready,
  input  logic [$clog2(VCHANNELS)-1:0]           desc_vc,
  input  logic [63:0]                            desc_time,
  input  logic [FLIT_DATA_WIDTH-1:0]             desc_header,
  input  logic [LEN_WIDTH-1:0]                   desc_len,
  input  logic [VCHANNELS*FLIT_DATA_WIDTH-1:0]   pld_data,
  input  logic [VCHANNELS-1:0]                   pld_empty,
  output logic [VCHANNELS-1:0]                   pld_rd_en,
  output logic [FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH-1:0] flit_source,
  output logic [VCHANNELS-1:0]                   valid_source,
  input  logic [VCHANNELS-1:0]                   ready_source,
  output logic [15:0]                            late_cnt,
  output logic                                   busy
);

  localparam int VCW = $clog2(VCHANNELS);
  localparam int DW  = 64 + FLIT_DATA_WIDTH + LEN_WIDTH;
  localparam int FW  = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;

  logic [VCHANNELS-1:0]       q_push, q_pop, q_full, q_empty, eligible;
  logic [DW-1:0]              q_rdata [VCHANNELS];
  logic [63:0]                q_time  [VCHANNELS];
  logic [FLIT_DATA_WIDTH-1:0] q_hdr   [VCHANNELS];
  logic [LEN_WIDTH-1:0]       q_len   [VCHANNELS];
  logic [FLIT_DATA_WIDTH-1:0] pld_arr [VCHANNELS];

  assign desc_ready = !q_full[desc_vc];

  for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
    assign q_push[v]  = desc_valid && desc_ready && (desc_vc == VCW'(v));
    assign q_time[v]  = q_rdata[v][DW-1 -: 64];
    assign q_hdr[v]   = q_rdata[v][LEN_WIDTH +: FLIT_DATA_WIDTH];
    assign q_len[v]   = q_rdata[v][LEN_WIDTH-1:0];
    assign eligible[v] = !q_empty[v] && (GTB >= q_time[v]);
    assign pld_arr[v] = pld_data[v*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];

    ttni_desc_fifo #(
      .WIDTH (DW),
      .DEPTH (DESC_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (reset_globle),
      .push  (q_push[v]),
      .pop   (q_pop[v]),
      .wdata ({desc_time, desc_header, desc_len}),
      .rdata (q_rdata[v]),
      .full  (q_full[v]),
      .empty (q_empty[v])
    );
  end

  sched_state_e               state_q, state_d;
  logic [VCW-1:0]             vc_q, vc_d, rr_q, rr_d, grant, idx_v;
  logic                       grant_valid;
  logic [FLIT_DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d, rem_q, rem_d;
  logic [15:0]                late_q, late_d;
  logic [FW-1:0]              flit_q, flit_d;
  logic [63:0]                slip;
  int                         idx;

  // Scan from the farthest offset down so the closest eligible VC at/after rr_q wins
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_v       = '0;
    for (int i = VCHANNELS - 1; i >= 0; i--) begin
      idx   = (int'(rr_q) + i) % VCHANNELS;
      idx_v = VCW'(idx);
      if (eligible[idx_v]) begin
        grant       = idx_v;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    vc_d         = vc_q;
    hdr_d        = hdr_q;
    len_d        = len_q;
    rem_d        = rem_q;
    rr_d         = rr_q;
    late_d       = late_q;
    flit_d       = flit_q;
    q_pop        = '0;
    valid_source = '0;
    pld_rd_en    = '0;
    busy         = 1'b0;
    slip         = GTB - q_time[grant];
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          q_pop[grant] = 1'b1;
          rr_d  = (grant == VCW'(VCHANNELS - 1)) ? '0 : grant + 1'b1;
          vc_d  = grant;
          hdr_d = q_hdr[grant];
          len_d = q_len[grant];
          if (slip > 64'(MAX_SLIP)) begin
            if (late_q != 16'hFFFF) late_d = late_q + 16'd1;
            if (LATE_DROP == 0) state_d = ST_HEAD;
          end else begin
            state_d = ST_HEAD;
          end
        end
      end
      ST_HEAD: begin
        busy               = 1'b1;
        valid_source[vc_q] = 1'b1;
        flit_d             = {(len_q == '0) ? FLIT_SINGLE : FLIT_HEAD, hdr_q};
        if (ready_source[vc_q]) begin
          if (len_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            rem_d   = len_q;
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        busy = 1'b1;
        // An empty payload FIFO withholds the flit rather than stalling mid-offer
        if (!pld_empty[vc_q]) begin
          valid_source[vc_q] = 1'b1;
          flit_d = {(rem_q == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY, pld_arr[vc_q]};
          if (ready_source[vc_q]) begin
            pld_rd_en[vc_q] = 1'b1;
            rem_d           = rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flit_source = flit_d;
  assign late_cnt    = late_q;

  always_ff @(posedge clk or posedge reset_globle) begin
    if (reset_globle) begin
      state_q <= ST_IDLE;
      vc_q    <= '0;
      rr_q    <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      late_q  <= '0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      rr_q    <= rr_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      late_q  <= late_d;
      flit_q  <= flit_d;
    end
  end

endmodule

// File: tb/tb_ttni_vc_source_sched.sv
// tb/tb_ttni_vc_source_sched.sv - directed scenarios with randomized data/backpressure against a queue model
module tb_ttni_vc_source_sched;
  import ttni_pkg::*;

  localparam int NV  = 2;
  localparam int FDW = 32;
  localparam int MS  = 16;
  localparam int LD  = 1;

  logic            clk = 1'b0;
  logic            reset_globle;
  logic [63:0]     GTB;
  logic            desc_valid;
  logic            desc_ready;
  logic [0:0]      desc_vc;
  logic [63:0]     desc_time;
  logic [31:0]     desc_header;
  logic [7:0]      desc_len;
  logic [NV*FDW-1:0] pld_data = '0;
  logic [NV-1:0]   pld_empty = '1;
  logic [NV-1:0]   pld_rd_en;
  logic [FDW+1:0]  flit_source;
  logic [NV-1:0]   valid_source;
  logic [NV-1:0]   ready_source = '1;
  logic [15:0]     late_cnt;
  logic            busy;

  ttni_vc_source_sched #(
    .VCHANNELS(NV), .FLIT_DATA_WIDTH(FDW), .FLIT_TYPE_WIDTH(2), .DESC_DEPTH(4),
    .LEN_WIDTH(8), .MAX_SLIP(MS), .LATE_DROP(LD)
  ) dut (
    .clk(clk), .reset_globle(reset_globle), .GTB(GTB),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_vc(desc_vc),
    .desc_time(desc_time), .desc_header(desc_header), .desc_len(desc_len),
    .pld_data(pld_data), .pld_empty(pld_empty), .pld_rd_en(pld_rd_en),
    .flit_source(flit_source), .valid_source(valid_source), .ready_source(ready_source),
    .late_cnt(late_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          vc;
    logic [33:0] flit;
  } fl_t;

  int n_cmp = 0;
  int n_mis = 0;

  desc_t       mq [NV][$];
  logic [31:0] pld_words [NV][$];
  int          rd_idx [NV];
  int          exp_idx [NV];
  int          m_rr = 0;
  int          m_late = 0;
  fl_t         rx[$];
  fl_t         ex[$];
  int          rd_pulses = 0;
  bit          rnd_mode = 0;
  logic [NV-1:0] pop_pend = '0;
  logic [NV-1:0] prev_v = '0, prev_r = '0;
  logic [33:0]   prev_f = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload source: FWFT word per VC, randomly starved, popped on the edge after rd_en
  always @(posedge clk) begin
    #1;
    for (int v = 0; v < NV; v++) begin
      bit starve;
      if (pop_pend[v]) rd_idx[v]++;
      ready_source[v] = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
      starve = rnd_mode && ($urandom_range(0, 9) < 2);
      if (rd_idx[v] < pld_words[v].size()) begin
        pld_data[v*FDW +: FDW] = pld_words[v][rd_idx[v]];
        pld_empty[v] = starve;
      end else begin
        pld_empty[v] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_globle) begin
      prev_v   = '0;
      pop_pend = '0;
    end else begin
      chk("onehot", 64'($countones(valid_source) <= 1), 1);
      for (int v = 0; v < NV; v++) begin
        chk("rd_en", pld_rd_en[v], valid_source[v] & ready_source[v] & ~flit_source[FDW]);
        if (prev_v[v] && !prev_r[v] && !pld_empty[v]) begin
          chk("hold_valid", valid_source[v], 1);
          chk("hold_flit", flit_source, prev_f);
        end
        if (valid_source[v] && ready_source[v]) rx.push_back('{v, flit_source});
        if (pld_rd_en[v]) rd_pulses++;
      end
      prev_v   = valid_source;
      prev_r   = ready_source;
      prev_f   = flit_source;
      pop_pend = pld_rd_en;
    end
  end

  task automatic push(input int vc, input logic [63:0] t, input logic [31:0] h, input int len,
                      input bit accept);
    desc_vc     = 1'(vc);
    desc_time   = t;
    desc_header = h;
    desc_len    = 8'(len);
    desc_valid  = 1'b1;
    #1;
    chk("desc_ready", desc_ready, 64'(accept));
    tick();
    desc_valid = 1'b0;
    if (accept) begin
      mq[vc].push_back('{t, h, 8'(len)});
      for (int k = 0; k < len; k++) pld_words[vc].push_back($urandom);
    end
  endtask

  // Drain all released descriptors at the current (frozen) GTB into an expected flit list
  task automatic model_drain();
    int          g;
    desc_t       d;
    logic [63:0] sl;
    forever begin
      g = -1;
      for (int k = 0; k < NV; k++) begin
        int v;
        v = (m_rr + k) % NV;
        if (g < 0 && mq[v].size() > 0 && GTB >= mq[v][0].rel_time) g = v;
      end
      if (g < 0) break;
      d    = mq[g].pop_front();
      m_rr = (g + 1) % NV;
      sl   = GTB - d.rel_time;
      if (sl > 64'(MS)) begin
        if (m_late < 65535) m_late++;
        if (LD != 0) continue;
      end
      ex.push_back('{g, {(d.len == 0) ? 2'b11 : 2'b01, d.header}});
      for (int k = 1; k <= int'(d.len); k++) begin
        ex.push_back('{g, {(k == int'(d.len)) ? 2'b10 : 2'b00, pld_words[g][exp_idx[g]]}});
        exp_idx[g]++;
      end
    end
  endtask

  task automatic drain(input string tag);
    int cyc;
    int nbody;
    cyc = 0;
    nbody = 0;
    model_drain();
    while ((rx.size() < ex.size() || busy) && cyc < 3000) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    chk({tag, "_count"}, rx.size(), ex.size());
    for (int i = 0; i < ex.size() && i < rx.size(); i++) begin
      chk({tag, "_vc"}, rx[i].vc, ex[i].vc);
      chk({tag, "_flit"}, rx[i].flit, ex[i].flit);
    end
    foreach (ex[i]) if (!ex[i].flit[FDW]) nbody++;
    chk({tag, "_rd_pulses"}, rd_pulses, nbody);
    chk({tag, "_late"}, late_cnt, m_late);
    chk({tag, "_idle"}, busy, 0);
    rx.delete();
    ex.delete();
    rd_pulses = 0;
  endtask

  initial begin
    int cyc;
    reset_globle = 1'b1;
    GTB = '0;
    desc_valid = 1'b0;
    desc_vc = '0;
    desc_time = '0;
    desc_header = '0;
    desc_len = '0;
    repeat (3) tick();
    chk("rst_valid", valid_source, 0);
    chk("rst_rd_en", pld_rd_en, 0);
    chk("rst_flit", flit_source, 0);
    chk("rst_late", late_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", desc_ready, 1);
    reset_globle = 1'b0;
    tick();
    rnd_mode = 1;

    // Release exactly at scheduled time
    GTB = 50;
    push(0, 100, 32'hA5, 2, 1);
    while (GTB < 99) begin
      GTB = GTB + 1;
      tick();
    end
    chk("s1_no_early", rx.size(), 0);
    chk("s1_busy_early", busy, 0);
    GTB = 100;
    tick();
    chk("s1_head_valid", valid_source, 2'b01);
    chk("s1_head_flit", flit_source, {2'b01, 32'hA5});
    drain("s1");

    // Single-flit packet on VC1
    push(1, GTB, $urandom, 0, 1);
    drain("s2");

    // Two round-robin ties
    for (int r = 0; r < 2; r++) begin
      push(0, 110, $urandom, $urandom_range(1, 3), 1);
      push(1, 110, $urandom, $urandom_range(1, 3), 1);
    end
    GTB = 110;
    drain("s3");

    // Late handling around the slip boundary
    GTB = 200;
    push(0, 0, $urandom, 3, 1);
    push(0, 184, $urandom, 2, 1);
    push(0, 183, $urandom, 1, 1);
    push(0, 200, $urandom, 0, 1);
    drain("s5");

    // Full queue: fifth push ignored
    GTB = 300;
    for (int k = 0; k < 4; k++) push(0, 1000, $urandom, $urandom_range(0, 2), 1);
    desc_vc = 1'b0;
    #1;
    chk("full_ready_vc0", desc_ready, 0);
    desc_vc = 1'b1;
    #1;
    chk("full_ready_vc1", desc_ready, 1);
    push(0, 1000, $urandom, 1, 0);
    GTB = 1000;
    drain("s6");

    // Asynchronous reset mid-body
    push(1, 5000, $urandom, 1, 1);
    push(0, 1000, $urandom, 6, 1);
    cyc = 0;
    while (rx.size() < 2 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("abort_reached_body", 64'(rx.size() >= 2), 1);
    @(posedge clk);
    #3;
    reset_globle = 1'b1;
    #1;
    chk("arst_valid", valid_source, 0);
    chk("arst_rd_en", pld_rd_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_late", late_cnt, 0);
    chk("arst_flit", flit_source, 0);
    tick();
    tick();
    reset_globle = 1'b0;
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      exp_idx[v] = rd_idx[v];
    end
    m_rr = 0;
    m_late = 0;
    rx.delete();
    ex.delete();
    rd_pulses = 0;
    GTB = 6000;
    repeat (10) tick();
    chk("post_rst_queues_empty", rx.size(), 0);
    chk("post_rst_busy", busy, 0);
    push(1, 7000, $urandom, 2, 1);
    push(0, 7000, $urandom, 1, 1);
    GTB = 7000;
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
